image_streamer: RTL

- Host-side transmitter for the accelerator's row-serial image interface. It is the inverse of the image reader.
- Latches a 14x14 binary image (196 bits) and streams it as 28 consecutive 7-bit rows with a framing strobe.
- Then waits for the classification-complete flag and captures the 4-bit BCD result.
- Used as the on-chip/FPGA stand-in for the Raspberry Pi driver and as the bench stimulus source for the accelerator top.

---
 rtl/image_streamer.sv | 102 ++++++++++
 1 files changed

// File: rtl/image_streamer.sv
// Row-serial image transmitter: latches a 14x14 binary image, streams it
// as 28 seven-bit rows under a framing strobe, then captures the BCD result.
module image_streamer #(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [195:0] image_in,
  output logic         busy,
  output logic [6:0]   row_out,
  output logic         frame_out,
  input  logic         done_in,
  input  logic [3:0]   bcd_in,
  output logic         result_valid,
  output logic [3:0]   result_bcd,
  output logic         timeout,
  output logic         bcd_err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PREP = 3'd1;
  localparam logic [2:0] SEND = 3'd2;
  localparam logic [2:0] WAIT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  ROW_LAST  = 5'd27;

  logic [2:0]   state;
  logic [195:0] img;
  logic [7:0]   gap_cnt;
  logic [4:0]   row_cnt;
  logic [15:0]  wait_cnt;

  // Frame sequencer; the image register shifts one row out per SEND cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      img        <= '0;
      gap_cnt    <= '0;
      row_cnt    <= '0;
      wait_cnt   <= '0;
      result_bcd <= '0;
      timeout    <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            img     <= image_in;
            gap_cnt <= '0;
            state   <= PREP;
          end
        end
        PREP: begin
          if (gap_cnt == GAP_LAST) begin
            row_cnt <= '0;
            state   <= SEND;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        SEND: begin
          img <= {7'd0, img[195:7]};
          if (row_cnt == ROW_LAST) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end else begin
            row_cnt <= row_cnt + 5'd1;
          end
        end
        WAIT: begin
          if (done_in) begin
            result_bcd <= bcd_in;
            timeout    <= 1'b0;
            bcd_err    <= (bcd_in > 4'd9);
            state      <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            result_bcd <= 4'hF;
            timeout    <= 1'b1;
            bcd_err    <= 1'b0;
            state      <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state so reset clears them at once
  assign busy         = (state != IDLE);
  assign frame_out    = (state == SEND) || (state == WAIT);
  assign row_out      = (state == SEND) ? img[6:0] : 7'd0;
  assign result_valid = (state == DONE);

endmodule
